// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle sequencing control unit for the 8-bit CPU.
// Accepts instructions over a valid/ready handshake, decodes the opcode and
// steps through FETCH -> DECODE -> EXEC -> WB. MUL and DIV hold EXEC for
// configurable latencies. HALT waits for a resume pulse.
// Optional macro ILLEGAL_OP_TRAP_EN: illegal opcodes trap into HALT and hold
// illegal_op high until resume or rst. When it is undefined, an illegal opcode
// acts as a NOP and raises a one-cycle illegal_op pulse.
module seq_control_unit #(
    parameter int INSTR_W    = 8,
    parameter int OPCODE_W   = 4,
    parameter int ALU_SEL_W  = 3,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 resume,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 alu_en,
    output logic                 reg_we,
    output logic                 flags_we,
    output logic                 pc_inc,
    output logic                 busy,
    output logic                 halted,
    output logic                 illegal_op
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_DIV  = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_CMP  = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(9);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t                state_q, state_next;
    logic [OPCODE_W-1:0]   opcode_q;
    logic [ALU_SEL_W-1:0]  alu_sel_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [OPCODE_W-1:0]   instr_opcode;
    logic                  is_alu_op;
    logic                  is_illegal;
    logic                  trap_q;

    assign instr_opcode = instr[INSTR_W-1 -: OPCODE_W];
    assign is_alu_op    = (opcode_q < OP_NOP);
    assign is_illegal   = (opcode_q > OP_HALT);
    assign alu_sel      = alu_sel_q;

    // Operand bits below the opcode are consumed by the datapath, not here.
    generate
        if (INSTR_W > OPCODE_W) begin : g_operand
            logic unused_operand;
            assign unused_operand = ^instr[INSTR_W-OPCODE_W-1:0];
        end
    endgenerate

    // State register, opcode capture, ALU select and EXEC cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            opcode_q  <= '0;
            alu_sel_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_next;
            if (state_q == S_FETCH && instr_valid) begin
                opcode_q <= instr_opcode;
            end
            if (state_q == S_DECODE && is_alu_op) begin
                alu_sel_q <= opcode_q[ALU_SEL_W-1:0];
                if (opcode_q == OP_MUL) begin
                    cnt_q <= CNT_W'(MUL_CYCLES);
                end else if (opcode_q == OP_DIV) begin
                    cnt_q <= CNT_W'(DIV_CYCLES);
                end else begin
                    cnt_q <= CNT_W'(1);
                end
            end else if (state_q == S_EXEC) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    // Sticky trap bit: set when an illegal opcode is decoded, cleared on resume.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else if (state_q == S_DECODE && is_illegal) begin
            trap_q <= 1'b1;
        end else if (state_q == S_HALT && resume) begin
            trap_q <= 1'b0;
        end
    end
`else
    assign trap_q = 1'b0;
`endif

    // Next-state and output decode; every output is forced low while rst is high.
    always_comb begin
        state_next  = state_q;
        instr_ready = 1'b0;
        alu_en      = 1'b0;
        reg_we      = 1'b0;
        flags_we    = 1'b0;
        pc_inc      = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                busy = 1'b1;
                if (is_alu_op) begin
                    state_next = S_EXEC;
                end else if (opcode_q == OP_NOP) begin
                    pc_inc     = 1'b1;
                    state_next = S_FETCH;
                end else if (opcode_q == OP_HALT) begin
                    state_next = S_HALT;
                end else begin
                    illegal_op = 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
                    state_next = S_HALT;
`else
                    pc_inc     = 1'b1;
                    state_next = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                busy   = 1'b1;
                alu_en = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_next = S_WB;
                end
            end
            S_WB: begin
                busy       = 1'b1;
                pc_inc     = 1'b1;
                flags_we   = (opcode_q == OP_CMP);
                reg_we     = (opcode_q != OP_CMP);
                state_next = S_FETCH;
            end
            S_HALT: begin
                halted     = 1'b1;
                illegal_op = trap_q;
                if (resume) begin
                    pc_inc     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
        if (rst) begin
            instr_ready = 1'b0;
            alu_en      = 1'b0;
            reg_we      = 1'b0;
            flags_we    = 1'b0;
            pc_inc      = 1'b0;
            busy        = 1'b0;
            halted      = 1'b0;
            illegal_op  = 1'b0;
        end
    end

endmodule
